// File: rtl/sram_ctrl16.sv
// sram_ctrl16: splits each 32-bit CPU word access into two 16-bit accesses
// on an external asynchronous SRAM. Big-endian: the even halfword (phase 0)
// carries data bits 31:16. Every SRAM and bus output comes from a flop.
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | waiting for bus_stb; strobes inactive
// HI     | halfword phase 0 (addr {A,0}, data 31:16), WAIT+1 cycles
// GAP    | write only: one cycle we_n high with data held (hold time)
// LO     | halfword phase 1 (addr {A,1}, data 15:0), WAIT+1 cycles
// DONE   | one-cycle bus_ack; strobes inactive; bus_stb ignored
module sram_ctrl16 #(
    parameter int WAIT = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        bus_stb,
    input  logic        bus_we,
    input  logic [21:0] bus_addr,
    input  logic [31:0] bus_din,
    output logic [31:0] bus_dout,
    output logic        bus_ack,
    output logic [22:0] sram_addr,
    output logic        sram_ce_n,
    output logic        sram_oe_n,
    output logic        sram_we_n,
    output logic        sram_ub_n,
    output logic        sram_lb_n,
    output logic [15:0] sram_dq_out,
    output logic        sram_dq_oe,
    input  logic [15:0] sram_dq_in
);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_HI   = 3'd1;
    localparam logic [2:0] S_GAP  = 3'd2;
    localparam logic [2:0] S_LO   = 3'd3;
    localparam logic [2:0] S_DONE = 3'd4;

    // Phase timer is a down-counter loaded with WAIT; terminal count is 0.
    localparam logic [3:0] WAIT_LD = 4'(WAIT);

    logic [2:0]  state, state_nxt;
    logic [3:0]  cnt, cnt_nxt;
    logic        we_q;
    logic [21:0] addr_q;
    logic [31:0] din_q;
    logic [15:0] hi_q;

    logic        we_eff;
    logic [21:0] addr_eff;
    logic [31:0] din_eff;
    logic        xfer_nxt;
    logic        act_nxt;
    logic        phase_nxt;
    logic        first_nxt;

    // Next-state and phase timer.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            S_IDLE: begin
                if (bus_stb) begin
                    state_nxt = S_HI;
                    cnt_nxt   = WAIT_LD;
                end
            end
            S_HI: begin
                if (cnt != 4'd0) begin
                    cnt_nxt = cnt - 4'd1;
                end else if (we_q) begin
                    state_nxt = S_GAP;
                end else begin
                    state_nxt = S_LO;
                    cnt_nxt   = WAIT_LD;
                end
            end
            S_GAP: begin
                state_nxt = S_LO;
                cnt_nxt   = WAIT_LD;
            end
            S_LO: begin
                if (cnt != 4'd0) begin
                    cnt_nxt = cnt - 4'd1;
                end else begin
                    state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
                cnt_nxt   = 4'd0;
            end
        endcase
    end

    // Outputs are registered from the next state, so the request fields must
    // come straight from the bus in the accepting IDLE cycle.
    always_comb begin
        we_eff    = (state == S_IDLE) ? bus_we   : we_q;
        addr_eff  = (state == S_IDLE) ? bus_addr : addr_q;
        din_eff   = (state == S_IDLE) ? bus_din  : din_q;
        xfer_nxt  = (state_nxt == S_HI) || (state_nxt == S_LO);
        act_nxt   = xfer_nxt || (state_nxt == S_GAP);
        phase_nxt = (state_nxt == S_LO);
        first_nxt = (cnt_nxt == WAIT_LD);
    end

    // State, request latch, registered SRAM strobes and read capture.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            cnt         <= 4'd0;
            we_q        <= 1'b0;
            addr_q      <= 22'd0;
            din_q       <= 32'd0;
            hi_q        <= 16'd0;
            sram_ce_n   <= 1'b1;
            sram_oe_n   <= 1'b1;
            sram_we_n   <= 1'b1;
            sram_ub_n   <= 1'b1;
            sram_lb_n   <= 1'b1;
            sram_dq_oe  <= 1'b0;
            sram_dq_out <= 16'd0;
            sram_addr   <= 23'd0;
            bus_ack     <= 1'b0;
            bus_dout    <= 32'd0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            if (state == S_IDLE && bus_stb) begin
                we_q   <= bus_we;
                addr_q <= bus_addr;
                din_q  <= bus_din;
            end
            sram_ce_n  <= !act_nxt;
            sram_ub_n  <= !act_nxt;
            sram_lb_n  <= !act_nxt;
            sram_oe_n  <= !(xfer_nxt && !we_eff);
            // First cycle of each write phase is address setup with we_n high.
            sram_we_n  <= !(xfer_nxt && we_eff && !first_nxt);
            sram_dq_oe <= act_nxt && we_eff;
            if (act_nxt) begin
                sram_addr <= {addr_eff, phase_nxt};
                if (we_eff) begin
                    sram_dq_out <= phase_nxt ? din_eff[15:0] : din_eff[31:16];
                end
            end
            bus_ack <= (state_nxt == S_DONE);
            if (state == S_HI && cnt == 4'd0 && !we_q) begin
                hi_q <= sram_dq_in;
            end
            if (state == S_LO && cnt == 4'd0 && !we_q) begin
                bus_dout <= {hi_q, sram_dq_in};
            end
        end
    end

endmodule

// File: doc/sram_ctrl16.md
Name: sram_ctrl16

Overview:
- Memory-side slave on the CPU word bus. It converts each 32-bit word read or write into two consecutive 16-bit accesses to an external asynchronous SRAM.
- Sits directly downstream of the CPU bus interface. It consumes that interface's stb/we/addr/write-data and returns read data plus ack.
- Byte-write read-modify-write is already split into a word read and a word write by the upstream stage, so this block handles word transfers only.
- Big-endian: the halfword at the even SRAM address carries data bits 31:16.

Parameters:
WAIT, 1, extra wait cycles per SRAM halfword phase; legal range 1..15; each phase lasts WAIT+1 cycles.

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
bus_stb  in  1  request from master; held high until bus_ack
bus_we  in  1  1 = write, 0 = read; stable while bus_stb is high
bus_addr  in  22  word address [23:2]
bus_din  in  32  write data from master
bus_dout  out  32  read data to master, registered
bus_ack  out  1  one-cycle completion strobe, registered
sram_addr  out  23  halfword address = {bus_addr, phase}; phase 0 = hi, 1 = lo
sram_ce_n  out  1  chip enable, active low
sram_oe_n  out  1  output enable, active low
sram_we_n  out  1  write enable, active low
sram_ub_n  out  1  upper byte enable, active low
sram_lb_n  out  1  lower byte enable, active low
sram_dq_out  out  16  write data to pads
sram_dq_oe  out  1  pad drive enable (tri-state resolved at top level)
sram_dq_in  in  16  read data from pads

Behaviour:
- All outputs registered.
- Reset values:
  - state IDLE, wait counter 0
  - sram_ce_n = sram_oe_n = sram_we_n = sram_ub_n = sram_lb_n = 1
  - sram_dq_oe = 0, sram_dq_out = 0, sram_addr = 0
  - bus_ack = 0, bus_dout = 0
- States: IDLE, HI, GAP, LO, DONE.
- IDLE:
  - bus_stb = 1 → latch we/addr/din, go to HI.
  - Otherwise stay in IDLE with all strobes inactive.
- Cycle numbering: cycle 0 is the IDLE cycle in which bus_stb is first seen.
- HI phase (cycles 1..WAIT+1):
  - ce_n = 0, ub_n = 0, lb_n = 0, addr = {A, 0}.
  - Read: oe_n = 0; sram_dq_in is captured into bits 31:16 in the last HI cycle.
  - Write: dq_oe = 1, dq_out = din[31:16] for the whole phase; we_n = 0 in every HI cycle except the first (address setup).
- GAP (write only, one cycle):
  - we_n = 1, dq_oe = 1, data held, ce_n = 0; gives write hold time.
  - Reads go HI → LO directly.
- LO phase (WAIT+1 cycles):
  - Same as HI with addr = {A, 1} and data bits 15:0.
  - The read capture in the last LO cycle is combined with the hi half into bus_dout, which updates in the DONE cycle.
- DONE:
  - bus_ack = 1 for exactly one cycle; all SRAM strobes inactive and dq_oe = 0.
  - Next state is always IDLE.
  - bus_stb is NOT sampled in DONE; the master may keep stb high for a new request, which IDLE accepts on the following cycle.
- Latency (cycles from cycle 0 to ack):
  - Read: ack in cycle 2*WAIT+3.
  - Write: ack in cycle 2*WAIT+4.
  - WAIT = 1 → read ack in cycle 5, write ack in cycle 6.
- Minimum spacing between back-to-back requests: one IDLE cycle after DONE.
- bus_dout holds the last read word until the next read's DONE; writes leave it unchanged.
- oe_n and dq_oe are never both active; a write always starts with dq_oe rising together with ce_n in the first HI cycle, while oe_n stays 1.
- bus_stb dropping mid-transaction (protocol violation): the transaction completes and acks normally.
- Reset mid-transaction:
  - Return to IDLE on the next edge with reset values.
  - we_n is forced high immediately; no ack is issued.
  - SRAM contents of the aborted word are undefined.

Test Plan:
- Reset, then idle 10 cycles with stb = 0 → all strobes high, dq_oe = 0, ack never asserted.
- WAIT = 1, write addr 22'h000010, data 32'hDEADBEEF:
  - HI drives sram_addr 23'h000020 / 16'hDEAD, LO drives 23'h000021 / 16'hBEEF.
  - we_n low exactly cycles 2 and 5; GAP in cycle 3; ack in cycle 6 only.
- WAIT = 1, read the same address with SRAM model returning 16'hDEAD / 16'hBEEF → bus_dout = 32'hDEADBEEF with ack in cycle 5; oe_n low cycles 1..4, dq_oe 0 throughout.
- Byte-write RMW sequence (read then write with stb held high across ack) → two distinct transactions, one IDLE cycle between them, exactly one ack each, no double execution.
- WAIT = 3 read → ack in cycle 9; each phase is 4 cycles and data is captured in the last cycle of each phase.
- Assert rst in cycle 2 of a write → next cycle we_n = 1, ce_n = 1, dq_oe = 0, no ack; a subsequent read completes correctly.
